// File: rtl/radiant_trig_pkg.sv
// Shared constants, event_info field offsets and FSM encoding for the coincidence trigger.
package radiant_trig_pkg;

   localparam int unsigned NCHAN      = 24;
   localparam int unsigned COUNT_W    = 5;

   localparam int unsigned CHAN_LSB   = 0;
   localparam int unsigned COUNT_LSB  = 24;
   localparam int unsigned FORCED_BIT = 31;

   typedef enum logic [1:0] {
      StArmed   = 2'd0,
      StHoldoff = 2'd1,
      StRearm   = 2'd2
   } trig_state_e;

   function automatic logic [COUNT_W-1:0] popcount31(input logic [30:0] v);
      logic [COUNT_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < 31; i++) begin
         acc = acc + COUNT_W'(v[i]);
      end
      return acc;
   endfunction

endpackage

// File: rtl/radiant_trig_stretch.sv
// One trigger channel: masked rising-edge detect feeding a reloadable stretch counter.
module radiant_trig_stretch #(
   parameter int unsigned STRETCH_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 trig_i,
   input  logic                 mask_i,
   input  logic [STRETCH_W-1:0] stretch_i,
   output logic                 win_o
);

   logic                 prev_q, prev_d;
   logic [STRETCH_W-1:0] cnt_q, cnt_d;
   logic                 edge_det;
   logic [STRETCH_W-1:0] load_val;

   assign edge_det = trig_i & ~prev_q & mask_i;
   assign load_val = (stretch_i == '0) ? STRETCH_W'(1) : stretch_i;

   // The mask only gates new edges, so clearing it leaves an open window running.
   always_comb begin
      prev_d = trig_i;
      cnt_d  = cnt_q;
      if (edge_det) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - STRETCH_W'(1);
      end
   end

   // Previous sample resets high so a level already present at reset release is not an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

   assign win_o = (cnt_q != '0);

endmodule

// File: rtl/radiant_trig_coinc.sv
// N-of-NCHAN coincidence trigger with holdoff, re-arm and busy suppression.
// Optional RADIANT_TRIG_COINC_FORCE_EN adds a force_i software trigger input.
module radiant_trig_coinc #(
   parameter int unsigned NCHAN     = radiant_trig_pkg::NCHAN,
   parameter int unsigned STRETCH_W = 8,
   parameter int unsigned HOLDOFF_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NCHAN-1:0]     trig_i,
   input  logic                 enable_i,
   input  logic [NCHAN-1:0]     chan_mask_i,
   input  logic [STRETCH_W-1:0] stretch_i,
   input  logic [4:0]           coinc_thresh_i,
   input  logic [HOLDOFF_W-1:0] holdoff_i,
   input  logic                 busy_i,
   input  logic                 cnt_clr_i,
`ifdef RADIANT_TRIG_COINC_FORCE_EN
   input  logic                 force_i,
`endif
   output logic                 event_o,
   output logic [31:0]          event_info_o,
   output logic [15:0]          dropped_cnt_o
);

   import radiant_trig_pkg::*;

   logic [NCHAN-1:0]     win;
   logic [NCHAN-1:0]     win_s1_q, win_q;
   logic [COUNT_W-1:0]   count_d, count_q, count_c_q;
   logic                 coinc_d, coinc_q, coinc_prev_q;

   trig_state_e          state_q, state_d;
   logic [HOLDOFF_W-1:0] hold_q, hold_d;
   logic                 event_q, event_d;
   logic [31:0]          info_q, info_d;
   logic [15:0]          dropped_q, dropped_d;

   logic                 force_fire;
   logic                 fire;
   logic [31:0]          info_new;

   for (genvar n = 0; n < NCHAN; n++) begin : g_chan
      radiant_trig_stretch #(
         .STRETCH_W (STRETCH_W)
      ) u_stretch (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .trig_i    (trig_i[n]),
         .mask_i    (chan_mask_i[n]),
         .stretch_i (stretch_i),
         .win_o     (win[n])
      );
   end

   assign count_d = popcount31(31'(win));
   assign coinc_d = enable_i & (coinc_thresh_i != '0) & (count_q >= coinc_thresh_i);

   // win and count are delayed alongside coinc so the info word matches the firing decision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         win_s1_q     <= '0;
         win_q        <= '0;
         count_q      <= '0;
         count_c_q    <= '0;
         coinc_q      <= 1'b0;
         coinc_prev_q <= 1'b0;
      end else begin
         win_s1_q     <= win;
         win_q        <= win_s1_q;
         count_q      <= count_d;
         count_c_q    <= count_q;
         coinc_q      <= coinc_d;
         coinc_prev_q <= coinc_q;
      end
   end

`ifdef RADIANT_TRIG_COINC_FORCE_EN
   assign force_fire = force_i;
`else
   assign force_fire = 1'b0;
`endif

   always_comb begin
      info_new                       = '0;
      info_new[CHAN_LSB +: NCHAN]    = win_q;
      info_new[COUNT_LSB +: COUNT_W] = count_c_q;
      info_new[FORCED_BIT]           = force_fire;
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      event_d   = 1'b0;
      info_d    = info_q;
      dropped_d = dropped_q;
      fire      = 1'b0;

      case (state_q)
         StArmed: begin
            if ((coinc_q | force_fire) & ~busy_i) begin
               fire = 1'b1;
            end else if (coinc_q & busy_i & ~coinc_prev_q & (dropped_q != 16'hFFFF)) begin
               dropped_d = dropped_q + 16'd1;
            end
         end
         StHoldoff: begin
            hold_d = hold_q - HOLDOFF_W'(1);
            if (hold_q <= HOLDOFF_W'(1)) begin
               state_d = StRearm;
            end
         end
         StRearm: begin
            if (!coinc_q) begin
               state_d = StArmed;
            end
         end
         default: state_d = StRearm;
      endcase

      if (fire) begin
         event_d = 1'b1;
         info_d  = info_new;
         hold_d  = holdoff_i;
         state_d = (holdoff_i == '0) ? StRearm : StHoldoff;
      end

      if (!enable_i) begin
         state_d = StRearm;
      end

      if (cnt_clr_i) begin
         dropped_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StArmed;
         hold_q    <= '0;
         event_q   <= 1'b0;
         info_q    <= '0;
         dropped_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         event_q   <= event_d;
         info_q    <= info_d;
         dropped_q <= dropped_d;
      end
   end

   assign event_o       = event_q;
   assign event_info_o  = info_q;
   assign dropped_cnt_o = dropped_q;

endmodule

// File: tb/tb_radiant_trig_coinc.sv
// Directed self-checking bench for radiant_trig_coinc.
module tb_radiant_trig_coinc;

   localparam int unsigned NCHAN     = 24;
   localparam int unsigned STRETCH_W = 8;
   localparam int unsigned HOLDOFF_W = 16;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b1;
   logic [NCHAN-1:0]     trig_i;
   logic                 enable_i;
   logic [NCHAN-1:0]     chan_mask_i;
   logic [STRETCH_W-1:0] stretch_i;
   logic [4:0]           coinc_thresh_i;
   logic [HOLDOFF_W-1:0] holdoff_i;
   logic                 busy_i;
   logic                 cnt_clr_i;
`ifdef RADIANT_TRIG_COINC_FORCE_EN
   logic                 force_i;
`endif
   logic                 event_o;
   logic [31:0]          event_info_o;
   logic [15:0]          dropped_cnt_o;

   int          n_checks = 0;
   int          n_errors = 0;
   int          ev_cnt   = 0;
   int          base;
   logic [31:0] last_info = '0;

   radiant_trig_coinc #(
      .NCHAN     (NCHAN),
      .STRETCH_W (STRETCH_W),
      .HOLDOFF_W (HOLDOFF_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .trig_i         (trig_i),
      .enable_i       (enable_i),
      .chan_mask_i    (chan_mask_i),
      .stretch_i      (stretch_i),
      .coinc_thresh_i (coinc_thresh_i),
      .holdoff_i      (holdoff_i),
      .busy_i         (busy_i),
      .cnt_clr_i      (cnt_clr_i),
`ifdef RADIANT_TRIG_COINC_FORCE_EN
      .force_i        (force_i),
`endif
      .event_o        (event_o),
      .event_info_o   (event_info_o),
      .dropped_cnt_o  (dropped_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (rst_ni && event_o === 1'b1) begin
         ev_cnt    = ev_cnt + 1;
         last_info = event_info_o;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_ni         = 1'b0;
      trig_i         = '1;
      enable_i       = 1'b1;
      chan_mask_i    = '1;
      stretch_i      = 8'd4;
      coinc_thresh_i = 5'd1;
      holdoff_i      = '0;
      busy_i         = 1'b0;
      cnt_clr_i      = 1'b0;
`ifdef RADIANT_TRIG_COINC_FORCE_EN
      force_i        = 1'b0;
`endif
      step(3);
      check_eq("rst_event", 32'(event_o), 32'd0);
      check_eq("rst_info", event_info_o, 32'h0);
      check_eq("rst_dropped", 32'(dropped_cnt_o), 32'd0);

      // Channels high at reset release must not look like edges.
      rst_ni = 1'b1;
      step(12);
      check_eq("high_at_release", 32'(ev_cnt), 32'd0);
      trig_i = '0;
      step(10);

      // Single channel: 3-cycle latency, one-cycle pulse.
      chan_mask_i    = 24'h000001;
      coinc_thresh_i = 5'd1;
      stretch_i      = 8'd4;
      trig_i[0]      = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         check_eq($sformatf("single_lat%0d", i), 32'(event_o), (i == 4) ? 32'd1 : 32'd0);
         if (i == 4) check_eq("single_info", event_info_o, 32'h0100_0001);
      end
      trig_i = '0;
      step(15);
      check_eq("single_count", 32'(ev_cnt), 32'd1);

      // 3-of-3 coincidence with edges 3 cycles apart.
      chan_mask_i    = 24'h000221;
      coinc_thresh_i = 5'd3;
      stretch_i      = 8'd8;
      base           = ev_cnt;
      trig_i[0]      = 1'b1;
      step(3);
      trig_i[5] = 1'b1;
      step(3);
      trig_i[9] = 1'b1;
      step(12);
      check_eq("coinc_count", 32'(ev_cnt), 32'(base + 1));
      check_eq("coinc_info", last_info, 32'h0300_0221);
      trig_i = '0;
      step(20);

      // Same edges 10 cycles apart never overlap.
      trig_i[0] = 1'b1;
      step(10);
      trig_i[5] = 1'b1;
      step(10);
      trig_i[9] = 1'b1;
      step(15);
      check_eq("spaced_no_event", 32'(ev_cnt), 32'(base + 1));
      trig_i = '0;
      step(20);

      // Holdoff then re-arm.
      holdoff_i = 16'd100;
      base      = ev_cnt;
      trig_i    = 24'h000221;
      step(45);
      check_eq("holdoff_first", 32'(ev_cnt), 32'(base + 1));
      trig_i = '0;
      step(1);
      trig_i = 24'h000221;
      step(30);
      check_eq("holdoff_ignored", 32'(ev_cnt), 32'(base + 1));
      check_eq("holdoff_not_dropped", 32'(dropped_cnt_o), 32'd0);
      trig_i = '0;
      step(80);
      trig_i = 24'h000221;
      step(10);
      check_eq("rearm_second", 32'(ev_cnt), 32'(base + 2));
      check_eq("rearm_info", last_info, 32'h0300_0221);
      trig_i = '0;
      step(120);
      holdoff_i = '0;

      // Busy suppression: five separate bursts are dropped and counted.
      busy_i = 1'b1;
      base   = ev_cnt;
      for (int b = 0; b < 5; b++) begin
         trig_i = 24'h000221;
         step(3);
         trig_i = '0;
         step(15);
      end
      check_eq("busy_no_event", 32'(ev_cnt), 32'(base));
      check_eq("busy_dropped", 32'(dropped_cnt_o), 32'd5);
      busy_i    = 1'b0;
      cnt_clr_i = 1'b1;
      step(1);
      cnt_clr_i = 1'b0;
      check_eq("dropped_clear", 32'(dropped_cnt_o), 32'd0);

      // Threshold 0 and enable low both block events.
      coinc_thresh_i = 5'd0;
      base           = ev_cnt;
      trig_i         = 24'h000221;
      step(12);
      trig_i = '0;
      step(12);
      check_eq("thresh0_no_event", 32'(ev_cnt), 32'(base));
      coinc_thresh_i = 5'd3;
      enable_i       = 1'b0;
      trig_i         = 24'h000221;
      step(12);
      trig_i = '0;
      step(5);
      enable_i = 1'b1;
      step(12);
      check_eq("disabled_no_event", 32'(ev_cnt), 32'(base));

      // Asynchronous reset in the middle of a window.
      chan_mask_i    = 24'h000001;
      coinc_thresh_i = 5'd1;
      stretch_i      = 8'd8;
      trig_i[0]      = 1'b1;
      step(4);
      check_eq("pre_reset_event", 32'(event_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check_eq("async_rst_event", 32'(event_o), 32'd0);
      check_eq("async_rst_info", event_info_o, 32'h0);
      step(2);
      rst_ni = 1'b1;
      base   = ev_cnt;
      step(12);
      check_eq("post_reset_no_event", 32'(ev_cnt), 32'(base));
      trig_i = '0;
      step(10);

`ifdef RADIANT_TRIG_COINC_FORCE_EN
      chan_mask_i = '0;
      holdoff_i   = 16'd20;
      base        = ev_cnt;
      force_i     = 1'b1;
      step(1);
      force_i = 1'b0;
      check_eq("force_event", 32'(event_o), 32'd1);
      check_eq("force_info", event_info_o, 32'h8000_0000);
      step(2);
      force_i = 1'b1;
      step(1);
      force_i = 1'b0;
      step(3);
      check_eq("force_in_holdoff", 32'(ev_cnt), 32'(base + 1));
      step(30);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
